// File: rtl/key_pkg.sv
// Shared encodings for the KEY press classifier and the downstream LED shifter.
package key_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD  = 2'b00,
        MODE_LEFT  = 2'b01,
        MODE_RIGHT = 2'b10
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HELD = 1'b1
    } state_e;

    localparam logic [3:0] SECONDS_MAX = 4'd15;

    // Debounced key level plus its one-cycle edge pulses.
    typedef struct packed {
        logic stable;
        logic rise;
        logic fall;
    } key_evt_t;

    function automatic mode_e classify_press(input logic [3:0] secs,
                                             input logic [3:0] left_min,
                                             input logic [3:0] right_min);
        if (secs < left_min)
            return MODE_HOLD;
        else if (secs < right_min)
            return MODE_LEFT;
        return MODE_RIGHT;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchroniser and counting debouncer for one active-low pushbutton.
module key_debounce
    import key_pkg::*;
#(
    parameter int DEB_CYCLES = 1000000
) (
    input  logic CLOCK_50Mhz,
    input  logic RESET,
    input  logic key_n,
    output logic stable,
    output logic rise,
    output logic fall
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic [1:0]    sync_q;
    logic          raw_p;
    logic          level_q;
    logic          stable_d;
    logic [CW-1:0] cnt_q;

    assign raw_p = ~sync_q[1];

    always_ff @(posedge CLOCK_50Mhz) begin
        if (RESET) begin
            sync_q   <= 2'b11;
            cnt_q    <= '0;
            level_q  <= 1'b0;
            stable   <= 1'b0;
            stable_d <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], key_n};
            stable   <= level_q;
            stable_d <= stable;
            // Only an uninterrupted run of DEB_CYCLES disagreeing samples moves the level.
            if (raw_p == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                level_q <= raw_p;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign rise = stable & ~stable_d;
    assign fall = ~stable & stable_d;

endmodule

// File: rtl/key_press_classifier.sv
// Times each debounced KEY press in whole seconds and classifies it on release.
module key_press_classifier
    import key_pkg::*;
#(
    parameter int TICK_DIV    = 50000000,
    parameter int DEB_CYCLES  = 1000000,
    parameter int LEFT_MIN_S  = 2,
    parameter int RIGHT_MIN_S = 4
) (
    input  logic       CLOCK_50Mhz,
    input  logic       RESET,
    input  logic       KEY_N,
    output logic       PRESSED,
    output logic [3:0] SECONDS,
    output logic [1:0] MODE,
    output logic       MODE_VALID
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [3:0]    LEFT_TH   = 4'(LEFT_MIN_S);
    localparam logic [3:0]    RIGHT_TH  = 4'(RIGHT_MIN_S);

    key_evt_t      evt;
    state_e        state_q, state_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [3:0]    sec_q, sec_d;
    mode_e         mode_q, mode_d;
    logic          valid_q, valid_d;

    key_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_debounce (
        .CLOCK_50Mhz (CLOCK_50Mhz),
        .RESET       (RESET),
        .key_n       (KEY_N),
        .stable      (evt.stable),
        .rise        (evt.rise),
        .fall        (evt.fall)
    );

    always_ff @(posedge CLOCK_50Mhz) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            tick_q  <= '0;
            sec_q   <= '0;
            mode_q  <= MODE_HOLD;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            sec_q   <= sec_d;
            mode_q  <= mode_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        sec_d   = sec_q;
        mode_d  = mode_q;
        valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (evt.rise) begin
                    state_d = ST_HELD;
                    tick_d  = '0;
                    sec_d   = '0;
                end
            end
            ST_HELD: begin
                // Release wins over a coincident tick, so that tick is never counted.
                if (evt.fall) begin
                    state_d = ST_IDLE;
                    mode_d  = classify_press(sec_q, LEFT_TH, RIGHT_TH);
                    valid_d = 1'b1;
                end else if (tick_q == TICK_LAST) begin
                    tick_d = '0;
                    if (sec_q != SECONDS_MAX)
                        sec_d = sec_q + 4'd1;
                end else begin
                    tick_d = tick_q + TW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign PRESSED    = evt.stable;
    assign SECONDS    = sec_q;
    assign MODE       = mode_q;
    assign MODE_VALID = valid_q;

endmodule

// File: tb/tb_key_press_classifier.sv
// Table-driven and scoreboard check of key_press_classifier with short timing parameters.
module tb_key_press_classifier;

    localparam int TICK_DIV    = 10;
    localparam int DEB_CYCLES  = 4;
    localparam int LEFT_MIN_S  = 2;
    localparam int RIGHT_MIN_S = 4;

    logic       CLOCK_50Mhz = 1'b0;
    logic       RESET = 1'b1;
    logic       KEY_N = 1'b1;
    logic       PRESSED;
    logic [3:0] SECONDS;
    logic [1:0] MODE;
    logic       MODE_VALID;

    always #5 CLOCK_50Mhz = ~CLOCK_50Mhz;

    key_press_classifier #(
        .TICK_DIV    (TICK_DIV),
        .DEB_CYCLES  (DEB_CYCLES),
        .LEFT_MIN_S  (LEFT_MIN_S),
        .RIGHT_MIN_S (RIGHT_MIN_S)
    ) dut (
        .CLOCK_50Mhz (CLOCK_50Mhz),
        .RESET       (RESET),
        .KEY_N       (KEY_N),
        .PRESSED     (PRESSED),
        .SECONDS     (SECONDS),
        .MODE        (MODE),
        .MODE_VALID  (MODE_VALID)
    );

    typedef struct {
        int         hold;
        logic       exp_valid;
        logic [3:0] exp_sec;
        logic [1:0] exp_mode;
    } vec_t;

    typedef struct {
        logic [3:0] sec;
        logic [1:0] mode;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Every MODE_VALID pulse must match the oldest outstanding expectation.
    always @(negedge CLOCK_50Mhz) begin
        if (MODE_VALID === 1'b1) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid: got pulse MODE=%0d SECONDS=%0d want no pulse", MODE, SECONDS);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sb_mode", MODE, e.mode);
                chk("sb_seconds", SECONDS, e.sec);
            end
        end
    end

    // Starts and ends on a falling clock edge; KEY_N is low for exactly 'hold' rising edges.
    task automatic run_press(input int idx, input vec_t v);
        if (v.exp_valid) sb_q.push_back('{v.exp_sec, v.exp_mode});
        KEY_N = 1'b0;
        for (int c = 1; c <= v.hold + 12; c++) begin
            @(negedge CLOCK_50Mhz);
            if (c == v.hold) KEY_N = 1'b1;
            if (c == 6) chk($sformatf("pressed_early[%0d]", idx), PRESSED, 0);
            if (c == 7) chk($sformatf("pressed_latency[%0d]", idx), PRESSED, v.hold >= DEB_CYCLES);
            if (c == v.hold + 6) chk($sformatf("pressed_before_fall[%0d]", idx), PRESSED, v.exp_valid);
            if (c == v.hold + 7) chk($sformatf("valid_not_early[%0d]", idx), MODE_VALID, 0);
            if (c == v.hold + 8) chk($sformatf("valid_latency[%0d]", idx), MODE_VALID, v.exp_valid);
        end
        chk($sformatf("sb_drained[%0d]", idx), sb_q.size(), 0);
        chk($sformatf("seconds_kept[%0d]", idx), SECONDS, v.exp_sec);
        chk($sformatf("mode_kept[%0d]", idx), MODE, v.exp_mode);
    endtask

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{3,   1'b0, 4'd0,  2'b00};
        vecs[1]  = '{4,   1'b1, 4'd0,  2'b00};
        vecs[2]  = '{9,   1'b1, 4'd0,  2'b00};
        vecs[3]  = '{11,  1'b1, 4'd1,  2'b00};
        vecs[4]  = '{20,  1'b1, 4'd1,  2'b00};
        vecs[5]  = '{21,  1'b1, 4'd2,  2'b01};
        vecs[6]  = '{35,  1'b1, 4'd3,  2'b01};
        vecs[7]  = '{40,  1'b1, 4'd3,  2'b01};
        vecs[8]  = '{41,  1'b1, 4'd4,  2'b10};
        vecs[9]  = '{55,  1'b1, 4'd5,  2'b10};
        vecs[10] = '{300, 1'b1, 4'd15, 2'b10};
        vecs[11] = '{2,   1'b0, 4'd15, 2'b10};

        repeat (3) @(negedge CLOCK_50Mhz);
        chk("rst_pressed", PRESSED, 0);
        chk("rst_seconds", SECONDS, 0);
        chk("rst_mode", MODE, 0);
        chk("rst_valid", MODE_VALID, 0);
        RESET = 1'b0;
        repeat (2) @(negedge CLOCK_50Mhz);

        for (int i = 0; i < 12; i++) run_press(i, vecs[i]);

        // Reset landing on the release edge suppresses the pulse.
        KEY_N = 1'b0;
        for (int c = 1; c <= 15 + 8; c++) begin
            @(negedge CLOCK_50Mhz);
            if (c == 15) KEY_N = 1'b1;
            if (c == 15 + 7) RESET = 1'b1;
        end
        RESET = 1'b0;
        chk("rstfall_valid", MODE_VALID, 0);
        chk("rstfall_seconds", SECONDS, 0);
        chk("rstfall_mode", MODE, 0);
        repeat (4) @(negedge CLOCK_50Mhz);
        chk("rstfall_quiet", MODE_VALID, 0);

        // Reset mid-press with the key still held: re-debounced and timed afresh.
        KEY_N = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge CLOCK_50Mhz);
            if (c == 28) chk("midrst_seconds_before", SECONDS, 2);
        end
        RESET = 1'b1;
        @(negedge CLOCK_50Mhz);
        RESET = 1'b0;
        chk("midrst_seconds", SECONDS, 0);
        chk("midrst_pressed", PRESSED, 0);
        chk("midrst_valid", MODE_VALID, 0);
        sb_q.push_back('{4'd3, 2'b01});
        for (int d = 1; d <= 31 + 12; d++) begin
            @(negedge CLOCK_50Mhz);
            if (d == 6) chk("midrst_pressed_early", PRESSED, 0);
            if (d == 7) chk("midrst_pressed_rerise", PRESSED, 1);
            if (d == 31) KEY_N = 1'b1;
        end
        chk("midrst_drained", sb_q.size(), 0);
        chk("midrst_mode", MODE, 2'b01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish before time limit");
        $fatal(1, "timeout");
    end

endmodule
